// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the command-FIFO reader: header field bounds,
// framing states and the beat layout carried through the output buffer.
package gpu_cmd_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 24;
    localparam int OPC_W    = OPC_HI - OPC_LO + 1;
    localparam int CMD_BW   = 32;
    localparam int LENW_DEF = 16;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic [CMD_BW-1:0] data;
        logic              first;
        logic              last;
        logic [OPC_W-1:0]  opcode;
    } cmd_beat_t;

    function automatic logic [OPC_W-1:0] hdr_opcode(input logic [CMD_BW-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/cmd_skid2.sv
// Two-entry valid/ready buffer for framed beats; entry 0 is always the head,
// so the output fields come straight from a register.
import gpu_cmd_pkg::*;

module cmd_skid2 #(
    parameter type beat_t = cmd_beat_t
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    input  beat_t      in_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_beat,
    output logic [1:0] occ
);

    logic [1:0] occ_q;
    logic [1:0] occ_d;
    beat_t      ent0_q;
    beat_t      ent1_q;
    beat_t      ent0_d;
    beat_t      ent1_d;
    logic       pop;

    assign pop = out_valid && out_ready;

    // Pop first, then append at the new tail, so a same-cycle pop and push
    // keeps the order and leaves the occupancy unchanged.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (in_valid) begin
            if (occ_d == 2'd0) begin
                ent0_d = in_beat;
            end else begin
                ent1_d = in_beat;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            occ_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_beat  = ent0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_cmd_reader.sv
// Drains the command FIFO one word per cycle, frames header + N payload words
// into packets and presents them as a first/last-tagged stream.
import gpu_cmd_pkg::*;

module fifo_cmd_reader #(
    parameter int BW   = 32,
    parameter int LENW = LENW_DEF
) (
    input  logic          clock,
    input  logic          resetn,
    output logic          fifo_rdreq,
    input  logic          fifo_empty,
    input  logic [BW-1:0] fifo_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_first,
    output logic          out_last,
    output logic [7:0]    out_opcode,
    output logic [31:0]   pkt_count,
    output logic          busy,
    output logic          dbg_state
);

    typedef struct packed {
        logic [BW-1:0]    data;
        logic             first;
        logic             last;
        logic [OPC_W-1:0] opcode;
    } beat_t;

    frame_state_t     state_q;
    frame_state_t     state_d;
    logic [LENW-1:0]  rem_q;
    logic [LENW-1:0]  rem_d;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] opc_d;
    logic             infl_q;
    logic [1:0]       occ;
    logic [2:0]       proj;
    logic             accept;
    logic [31:0]      pkt_count_q;
    logic [31:0]      pkt_count_d;
    beat_t            cap_beat;
    beat_t            head;

    // Output stream: a beat transfers on a rising edge where out_valid && out_ready.
    // out_valid comes from registered occupancy only, and a presented beat holds
    // every field until it transfers.
    assign accept = out_valid && out_ready;

    // Projected occupancy once this cycle's capture and accept settle; a new
    // pop is allowed only if its word will still find a free slot next cycle.
    assign proj       = {1'b0, occ} + {2'b00, infl_q} - {2'b00, accept};
    assign fifo_rdreq = resetn && !fifo_empty && (proj < 3'd2);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        opc_d    = opc_q;
        cap_beat = '{data: fifo_q, first: 1'b0, last: 1'b0, opcode: opc_q};
        if (infl_q) begin
            case (state_q)
                HDR: begin
                    opc_d           = hdr_opcode(fifo_q[CMD_BW-1:0]);
                    rem_d           = fifo_q[LENW-1:0];
                    cap_beat.first  = 1'b1;
                    cap_beat.opcode = opc_d;
                    if (fifo_q[LENW-1:0] == '0) begin
                        cap_beat.last = 1'b1;
                    end else begin
                        state_d = PAY;
                    end
                end
                PAY: begin
                    cap_beat.last = (rem_q == LENW'(1));
                    rem_d         = rem_q - LENW'(1);
                    if (rem_q == LENW'(1)) begin
                        state_d = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    assign pkt_count_d = pkt_count_q + 32'(accept && out_last);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= HDR;
            rem_q       <= '0;
            opc_q       <= '0;
            infl_q      <= 1'b0;
            pkt_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            opc_q       <= opc_d;
            infl_q      <= fifo_rdreq;
            pkt_count_q <= pkt_count_d;
        end
    end

    cmd_skid2 #(
        .beat_t(beat_t)
    ) u_skid (
        .clock    (clock),
        .resetn   (resetn),
        .in_valid (infl_q),
        .in_beat  (cap_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_beat (head),
        .occ      (occ)
    );

    assign out_data   = head.data;
    assign out_first  = head.first;
    assign out_last   = head.last;
    assign out_opcode = head.opcode;
    assign pkt_count  = pkt_count_q;
    assign busy       = (state_q == PAY) || (occ != 2'd0) || infl_q;
    assign dbg_state  = logic'(state_q);

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Bench for fifo_cmd_reader: FIFO model, directed packets with hand-computed
// beats queued for a negedge monitor, and a summary line.
`timescale 1ns/1ps

module tb_fifo_cmd_reader;

    localparam int BW = 32;
    localparam int EW = BW + 10;

    logic          clock;
    logic          resetn;
    logic          fifo_rdreq;
    logic          fifo_empty;
    logic [BW-1:0] fifo_q;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [7:0]    out_opcode;
    logic [31:0]   pkt_count;
    logic          busy;
    logic          dbg_state;

    logic [BW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    fifo_cmd_reader dut (
        .clock     (clock),
        .resetn    (resetn),
        .fifo_rdreq(fifo_rdreq),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_opcode(out_opcode),
        .pkt_count (pkt_count),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    assign fifo_empty = (wr_ptr == rd_ptr);

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_word(input logic [BW-1:0] w, input logic first, input logic last,
                             input logic [7:0] opc);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
        exp_q.push_back({w, first, last, opc});
    endtask

    task automatic push_raw(input logic [BW-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && n < 100) begin
            tick();
            n++;
        end
        check({name, "_drain"}, 64'(n < 100), 64'd1);
    endtask

    // ---------------- FIFO model: data valid the cycle after a pop ----------------
    initial begin
        logic do_pop;
        fifo_q = '0;
        forever begin
            @(negedge clock);
            do_pop = fifo_rdreq;
            if (do_pop) check("rdreq_while_empty", 64'(fifo_empty), 64'd0);
            @(posedge clock);
            #1;
            if (do_pop && rd_ptr != wr_ptr) begin
                fifo_q = fifo_mem[rd_ptr];
                rd_ptr++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic          stalled;
        logic [EW-1:0] held;
        logic [EW-1:0] cur;
        logic [EW-1:0] exp;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            cur = {out_data, out_first, out_last, out_opcode};
            if (!resetn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("hold_stable", {21'd0, out_valid, cur}, {21'd0, 1'b1, held});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h want none", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat", 64'(cur), 64'(exp));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = cur;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] pat;
        pat       = 4'b1001;
        resetn    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();

        check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_first", 64'(out_first), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_opcode", 64'(out_opcode), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        resetn = 1'b1;
        tick();

        // Header N=2 plus two payload words, streaming back to back.
        out_ready = 1'b1;
        push_word(32'h0500_0002, 1'b1, 1'b0, 8'h05);
        push_word(32'hAAAA_0001, 1'b0, 1'b0, 8'h05);
        push_word(32'hBBBB_0002, 1'b0, 1'b1, 8'h05);
        tick();
        check("t1_latency", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_back_to_back", 64'(out_valid), 64'd1);
        end
        wait_idle("t1");
        check("t1_pkt_count", 64'(pkt_count), 64'd1);

        // Zero-length packet: header is both first and last.
        push_word(32'h0700_0000, 1'b1, 1'b1, 8'h07);
        wait_idle("t2");
        check("t2_pkt_count", 64'(pkt_count), 64'd2);

        // Eight words under a 1,0,0,1 ready pattern.
        push_word(32'h0A00_0007, 1'b1, 1'b0, 8'h0A);
        for (int i = 1; i <= 6; i++) push_word(32'h1000_0000 + i, 1'b0, 1'b0, 8'h0A);
        push_word(32'h1000_0007, 1'b0, 1'b1, 8'h0A);
        for (int c = 0; c < 40; c++) begin
            out_ready = pat[c % 4];
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t3");
        check("t3_pkt_count", 64'(pkt_count), 64'd3);

        // FIFO held empty: nothing requested, nothing presented.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_rdreq", 64'(fifo_rdreq), 64'd0);
            check("idle_valid", 64'(out_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end

        // Reset in the middle of an N=4 packet, then a fresh packet.
        out_ready = 1'b0;
        push_raw(32'h0300_0004);
        push_raw(32'hCCCC_0001);
        repeat (4) tick();
        check("t5_busy_mid_packet", 64'(busy), 64'd1);
        check("t5_state_payload", 64'(dbg_state), 64'd1);
        resetn = 1'b0;
        repeat (2) tick();
        check("t5_rst_pkt_count", 64'(pkt_count), 64'd0);
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_state", 64'(dbg_state), 64'd0);
        resetn = 1'b1;
        tick();
        out_ready = 1'b1;
        push_word(32'h0900_0001, 1'b1, 1'b0, 8'h09);
        push_word(32'h0000_0099, 1'b0, 1'b1, 8'h09);
        wait_idle("t5");
        check("t5_pkt_count", 64'(pkt_count), 64'd1);

        // Packet counter wraps modulo 2^32.
        force dut.pkt_count_q = 32'hFFFF_FFFE;
        tick();
        release dut.pkt_count_q;
        check("t6_preload", 64'(pkt_count), 64'hFFFF_FFFE);
        push_word(32'h0100_0000, 1'b1, 1'b1, 8'h01);
        push_word(32'h0200_0000, 1'b1, 1'b1, 8'h02);
        wait_idle("t6");
        check("t6_wrap", 64'(pkt_count), 64'd0);

        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
